// File: rtl/seq_restoring_divider.sv
// Iterative signed restoring divider: one quotient bit per cycle through a shared
// subtract stage, with sign fix-up, divide-by-zero and MIN/-1 overflow reporting.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] dvd_q;      // dividend magnitude, shifts out MSB-first while quotient bits shift in
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    count;
    logic             sign_q, sign_r, ovf;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] shifted, diff;
    logic             borrow, accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign a_mag    = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag    = divisor[WIDTH-1]  ? -divisor  : divisor;

    // Subtract stage: the partial remainder never exceeds |b|-1, so the top bit of
    // the shifted value is always 0 and diff's MSB is a clean borrow.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = shifted - {2'b00, dvs_mag};
    assign borrow  = diff[WIDTH+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (divisor == '0) ? DONE : CALC;
            CALC: if (count == CW'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every register here, including the operand and result holding registers,
    // is cleared by reset so a dropped division leaves no stale result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_mag     <= '0;
            rem_q       <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            ovf         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: if (accept) begin
                    dvd_q   <= a_mag;
                    dvs_mag <= b_mag;
                    rem_q   <= '0;
                    count   <= CW'(WIDTH);
                    sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sign_r  <= dividend[WIDTH-1];
                    ovf     <= (dividend == MIN_VAL) && (divisor == '1);
                end
                CALC: begin
                    count <= count - CW'(1);
                    dvd_q <= {dvd_q[WIDTH-2:0], ~borrow};
                    rem_q <= borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
                end
                FIX: begin
                    quotient    <= sign_q ? -dvd_q : dvd_q;
                    remainder   <= sign_r ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    overflow    <= ovf;
                    div_by_zero <= 1'b0;
                    out_valid   <= 1'b1;
                end
                DONE: begin
                    // Entering DONE with out_valid low only happens on the divide-by-zero path.
                    if (!out_valid) begin
                        quotient    <= '1;
                        remainder   <= sign_r ? -dvd_q : dvd_q;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                        out_valid   <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4) using a result scoreboard
// filled from a truncating-division reference model.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, div_by_zero, overflow;
    logic [W-1:0] dividend, divisor, quotient, remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        exp_t e;
        int   ai, bi;
        ai   = a;
        bi   = b;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (bi == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = W'(ai / bi);
            e.r  = W'(ai % bi);
            e.ov = (ai / bi) > 7;
        end
        return e;
    endfunction

    task automatic accept_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        sb.push_back(model(a, b));
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called 1 time unit after the accept edge; counts edges until out_valid appears.
    task automatic collect(input int exp_lat);
        exp_t e;
        int   n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: got empty expected entry");
            $fatal(1);
        end
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        check("overflow", 32'(overflow), 32'(e.ov));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check("out_valid_drop", 32'(out_valid), 32'd0);
            check("in_ready_after", 32'(in_ready), 32'd1);
        end
    endtask

    logic signed [W-1:0] ta [11] = '{4'sd7, -4'sd7, 4'sd7, 4'sh8, 4'sh8, 4'sd5, -4'sd1, 4'sd0, 4'sh8, 4'sd3, 4'sh8};
    logic signed [W-1:0] tb [11] = '{4'sd2, 4'sd2, -4'sd2, -4'sd1, 4'sd1, 4'sd0, 4'sd3, 4'sd5, 4'sd0, 4'sd7, 4'sh8};

    initial begin
        exp_t                e;
        int                  n;
        int                  seen;
        logic signed [W-1:0] ra, rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table: signs, MIN/-1 overflow, MIN/1, divide-by-zero, zero dividend.
        for (int i = 0; i < 11; i++) begin
            accept_op(ta[i], tb[i]);
            collect((tb[i] == 0) ? 1 : 5);
        end

        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom_range(15));
            rb = W'($urandom_range(15));
            accept_op(ra, rb);
            collect((rb == 0) ? 1 : 5);
        end

        // Back-pressure for 10 cycles with a competing operand pair held on the input.
        out_ready = 1'b0;
        accept_op(4'sd7, 4'sd2);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_latency", 32'(n), 32'd5);
        e = sb.pop_front();
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_quotient", 32'(quotient), 32'(e.q));
            check("bp_remainder", 32'(remainder), 32'(e.r));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        sb.push_back(model(4'sd6, 4'sd3));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("followup_accepted", 32'(in_ready), 32'd0);
        collect(5);

        // Reset pulse in the middle of CALC drops the division.
        accept_op(4'sd6, 4'sd3);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("no_result_after_rst", 32'(seen), 32'd0);
        accept_op(4'sd6, 4'sd3);
        collect(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
